// File: rtl/conv_window_stream.sv
// Raster pixel stream in, KxK stride-S windows out via K-1 line buffers; CONV_WIN_COORD_EN adds window coordinates.
// Latency: window registered 1 cycle after its bottom-right pixel is accepted.
// Backpressure: in_ready = !o_valid || o_ready; a stalled window holds stable and input stops.
module conv_window_stream #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int K          = 3,
    parameter int STRIDE     = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_pixel,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [K*K*DATA_WIDTH-1:0]    o_window,
    output logic                         o_last
`ifdef CONV_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0]     o_win_row,
    output logic [$clog2(IMG_W)-1:0]     o_win_col
`endif
);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int PW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int DW     = DATA_WIDTH;
    localparam int LAST_R = (K - 1) + ((IMG_H - K) / STRIDE) * STRIDE;
    localparam int LAST_C = (K - 1) + ((IMG_W - K) / STRIDE) * STRIDE;

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(LAST_C);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(LAST_R);
    localparam logic [PW-1:0] PH_MAX   = PW'(STRIDE - 1);

    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;
    logic [PW-1:0]          r_col_ph;
    logic [PW-1:0]          r_row_ph;
    logic [DW-1:0]          r_lb [K-1][IMG_W];
    logic [K*K*DW-1:0]      r_shift;
    logic                   w_acc;
    logic                   w_emit;
    logic                   w_last;
    logic [K*K*DW-1:0]      w_win;

    function automatic logic [PW-1:0] ph_inc(input logic [PW-1:0] p);
        return (p == PH_MAX) ? '0 : p + PW'(1);
    endfunction

    assign in_ready = !o_valid || o_ready;
    assign w_acc    = in_valid && in_ready && !flush;
    // Phase counters are zero exactly at K-1, K-1+S, ... so the >= K-1 test gates stale data.
    assign w_emit   = (r_row >= ROW_K1) && (r_col >= COL_K1) &&
                      (r_row_ph == '0) && (r_col_ph == '0);
    assign w_last   = (r_row == ROW_LAST) && (r_col == COL_LAST);

    always_comb begin
        w_win = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                w_win[(r*K+c)*DW +: DW] = r_shift[(r*K+c+1)*DW +: DW];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            w_win[(r*K+K-1)*DW +: DW] = r_lb[K-2-r][r_col];
        end
        w_win[(K*K-1)*DW +: DW] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb[0][r_col] <= in_pixel;
            for (int i = 1; i < K - 1; i++) begin
                r_lb[i][r_col] <= r_lb[i-1][r_col];
            end
            r_shift <= w_win;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (flush) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (w_acc) begin
            if (r_col == COL_MAX) begin
                r_col    <= '0;
                r_col_ph <= '0;
                if (r_row == ROW_MAX) begin
                    r_row    <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row    <= r_row + RW'(1);
                    r_row_ph <= (r_row < ROW_K1) ? '0 : ph_inc(r_row_ph);
                end
            end else begin
                r_col    <= r_col + CW'(1);
                r_col_ph <= (r_col < COL_K1) ? '0 : ph_inc(r_col_ph);
            end
        end
    end

`ifdef CONV_WIN_COORD_EN
    logic [RW-1:0] r_wr;
    logic [CW-1:0] r_wc;

    // Output-map index advances each time the matching phase counter wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_wc <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_wc <= '0;
        end else if (w_acc) begin
            if (r_col == COL_MAX) begin
                r_wc <= '0;
                if (r_row == ROW_MAX) begin
                    r_wr <= '0;
                end else begin
                    r_wr <= (r_row < ROW_K1) ? '0 :
                            (r_row_ph == PH_MAX) ? r_wr + RW'(1) : r_wr;
                end
            end else begin
                r_wc <= (r_col < COL_K1) ? '0 :
                        (r_col_ph == PH_MAX) ? r_wc + CW'(1) : r_wc;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_window  <= '0;
`ifdef CONV_WIN_COORD_EN
            o_win_row <= '0;
            o_win_col <= '0;
`endif
        end else if (flush) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_window  <= '0;
`ifdef CONV_WIN_COORD_EN
            o_win_row <= '0;
            o_win_col <= '0;
`endif
        end else begin
            if (o_valid && o_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
            if (w_acc && w_emit) begin
                o_valid   <= 1'b1;
                o_last    <= w_last;
                o_window  <= w_win;
`ifdef CONV_WIN_COORD_EN
                o_win_row <= r_wr;
                o_win_col <= r_wc;
`endif
            end
        end
    end
endmodule

// File: tb/tb_conv_window_stream.sv
// Directed bench for conv_window_stream: 4x4 S1, 28x28 S1 and 5x5 S2 instances, checked against hand vectors and a window model.
// Covers reset state, latency, frame wrap, backpressure, random stalls, mid-frame reset and flush.
module tb_conv_window_stream;
    typedef logic [159:0] val_t;
    typedef int arr9_t[9];

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   flush;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   o_valid;
    logic [2:0]   o_ready;
    logic [2:0]   o_last;
    logic [15:0]  pix [3];
    logic [143:0] win [3];
`ifdef CONV_WIN_COORD_EN
    logic [1:0]   wr0, wc0;
    logic [4:0]   wr1, wc1;
    logic [2:0]   wr2, wc2;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   sel_m = 0;
    int   first_cyc = -1;
    int   acc10 = 0;
    val_t q[$];
    val_t qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_stream #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .DATA_WIDTH(16)) u_s4 (
        .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_pixel(pix[0]), .o_valid(o_valid[0]), .o_ready(o_ready[0]), .o_window(win[0]), .o_last(o_last[0])
`ifdef CONV_WIN_COORD_EN
        , .o_win_row(wr0), .o_win_col(wc0)
`endif
    );

    conv_window_stream #(.IMG_W(28), .IMG_H(28), .K(3), .STRIDE(1), .DATA_WIDTH(16)) u_s28 (
        .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_pixel(pix[1]), .o_valid(o_valid[1]), .o_ready(o_ready[1]), .o_window(win[1]), .o_last(o_last[1])
`ifdef CONV_WIN_COORD_EN
        , .o_win_row(wr1), .o_win_col(wc1)
`endif
    );

    conv_window_stream #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .DATA_WIDTH(16)) u_s5 (
        .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_pixel(pix[2]), .o_valid(o_valid[2]), .o_ready(o_ready[2]), .o_window(win[2]), .o_last(o_last[2])
`ifdef CONV_WIN_COORD_EN
        , .o_win_row(wr2), .o_win_col(wc2)
`endif
    );

    // Record every consumed window of the instance under test.
    always @(negedge clk) begin
        if (o_valid[sel_m] && o_ready[sel_m]) begin
            q.push_back(val_t'({o_last[sel_m], win[sel_m]}));
            if (first_cyc < 0) first_cyc = cyc;
`ifdef CONV_WIN_COORD_EN
            if (sel_m == 2) qc.push_back(val_t'({wr2, wc2}));
`endif
        end
    end

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic val_t pk(input arr9_t e, input logic last);
        val_t v = '0;
        for (int i = 0; i < 9; i++) v[i*16 +: 16] = 16'(e[i]);
        v[144] = last;
        return v;
    endfunction

    function automatic val_t mwin(input int w, input int tr, input int tc, input logic last);
        arr9_t e;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                e[r*3+c] = (tr + r) * w + tc + c;
        return pk(e, last);
    endfunction

    task automatic clear_q();
        q.delete();
        qc.delete();
        first_cyc = -1;
    endtask

    // Streams npix raster pixels (value = position in frame); starts and ends at posedge+1.
    task automatic run(input int sel, input int w, input int h, input int npix,
                       input int vpct, input int rpct, input bit stall5);
        int   idx = 0;
        int   guard = 0;
        int   sc = 0;
        bit   stalling;
        logic [143:0] held = '0;
        while (idx < npix && guard < 20000) begin
            in_valid[sel] = ($urandom_range(99) < vpct);
            pix[sel]      = 16'(idx % (w * h));
            o_ready[sel]  = ($urandom_range(99) < rpct);
            stalling      = stall5 && (sc < 5) && o_valid[sel];
            if (stalling) begin
                o_ready[sel] = 1'b0;
                if (sc == 0) held = win[sel];
                sc++;
            end
            @(negedge clk);
            if (stalling) begin
                check("bp_win", val_t'(win[sel]), val_t'(held));
                check("bp_in_rdy", val_t'(in_ready[sel]), val_t'(0));
            end
            if (in_valid[sel] && in_ready[sel]) begin
                if (idx == 10) acc10 = cyc;
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        check("run_done", val_t'(idx), val_t'(npix));
    endtask

    task automatic drain(input int sel);
        in_valid[sel] = 1'b0;
        o_ready[sel]  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input int w, input int h, input int s, input int nfr);
        int nr  = (h - 3) / s + 1;
        int nc  = (w - 3) / s + 1;
        int per = nr * nc;
        int k;
        check({tag, "_cnt"}, val_t'(q.size()), val_t'(nfr * per));
        for (int i = 0; i < q.size() && i < nfr * per; i++) begin
            k = i % per;
            check({tag, "_win"}, q[i], mwin(w, (k / nc) * s, (k % nc) * s, k == per - 1));
        end
    endtask

    initial begin
        rst      = 1'b0;
        flush    = '0;
        in_valid = '0;
        o_ready  = '1;
        for (int i = 0; i < 3; i++) pix[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", val_t'(o_valid), val_t'(0));
        check("rst_last", val_t'(o_last), val_t'(0));
        check("rst_win4", val_t'(win[0]), val_t'(0));
        check("rst_win28", val_t'(win[1]), val_t'(0));
        check("rst_win5", val_t'(win[2]), val_t'(0));
        check("rst_in_rdy", val_t'(in_ready), val_t'(3'b111));
        rst = 1'b1;
        @(posedge clk); #1;

        // 4x4, K=3, S=1
        sel_m = 0;
        clear_q();
        run(0, 4, 4, 16, 100, 100, 0);
        drain(0);
        check("t1_cnt", val_t'(q.size()), val_t'(4));
        check("t1_w0", q[0], pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}, 1'b0));
        check("t1_w1", q[1], pk('{1, 2, 3, 5, 6, 7, 9, 10, 11}, 1'b0));
        check("t1_w2", q[2], pk('{4, 5, 6, 8, 9, 10, 12, 13, 14}, 1'b0));
        check("t1_w3", q[3], pk('{5, 6, 7, 9, 10, 11, 13, 14, 15}, 1'b1));
        check("t1_lat", val_t'(first_cyc), val_t'(acc10 + 1));

        // 28x28, two back-to-back frames
        sel_m = 1;
        clear_q();
        run(1, 28, 28, 1568, 100, 100, 0);
        drain(1);
        verify("t2", 28, 28, 1, 2);

        // 5x5, K=3, S=2
        sel_m = 2;
        clear_q();
        run(2, 5, 5, 25, 100, 100, 0);
        drain(2);
        check("t3_cnt", val_t'(q.size()), val_t'(4));
        check("t3_w0", q[0], pk('{0, 1, 2, 5, 6, 7, 10, 11, 12}, 1'b0));
        check("t3_w1", q[1], pk('{2, 3, 4, 7, 8, 9, 12, 13, 14}, 1'b0));
        check("t3_w2", q[2], pk('{10, 11, 12, 15, 16, 17, 20, 21, 22}, 1'b0));
        check("t3_w3", q[3], pk('{12, 13, 14, 17, 18, 19, 22, 23, 24}, 1'b1));
`ifdef CONV_WIN_COORD_EN
        check("t3_c0", qc[0], val_t'(6'o00));
        check("t3_c1", qc[1], val_t'(6'o01));
        check("t3_c2", qc[2], val_t'(6'o10));
        check("t3_c3", qc[3], val_t'(6'o11));
`endif

        // 5-cycle stall on the first window, then full frame
        sel_m = 1;
        clear_q();
        run(1, 28, 28, 784, 100, 100, 1);
        drain(1);
        verify("t4", 28, 28, 1, 1);

        // 50% random valid/ready
        clear_q();
        run(1, 28, 28, 784, 50, 50, 0);
        drain(1);
        verify("t5", 28, 28, 1, 1);

        // reset after pixel 40, then a fresh frame
        run(1, 28, 28, 41, 100, 100, 0);
        rst = 1'b0;
        #1;
        check("t6_rst_vld", val_t'(o_valid[1]), val_t'(0));
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_q();
        run(1, 28, 28, 784, 100, 100, 0);
        drain(1);
        verify("t6", 28, 28, 1, 1);

        // flush after pixel 60 (window pending), flush-cycle pixel must be dropped
        run(1, 28, 28, 61, 100, 100, 0);
        flush[1]    = 1'b1;
        in_valid[1] = 1'b1;
        pix[1]      = 16'h03e7;
        @(posedge clk); #1;
        flush[1]    = 1'b0;
        in_valid[1] = 1'b0;
        check("t7_fl_vld", val_t'(o_valid[1]), val_t'(0));
        check("t7_fl_last", val_t'(o_last[1]), val_t'(0));
        check("t7_fl_win", val_t'(win[1]), val_t'(0));
        clear_q();
        run(1, 28, 28, 784, 100, 100, 0);
        drain(1);
        verify("t7", 28, 28, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
